yarp_lsu: RTL and testbench

Parametrised load/store unit between the execute stage and a request/grant/response data-memory bus. It drives byte-lane strobes from address offset and access size, and steers write data into the correct lanes. Read data is shifted back down and sign- or zero-extended. It is multi-cycle with a state machine, and can split word-crossing misaligned accesses into two bus beats.

---
 rtl/yarp_lsu.sv | 242 ++++++++++++++++++++++++
 tb/tb_yarp_lsu.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_lsu.sv
// yarp_lsu: load/store unit between the execute stage and a
// request/grant/response data-memory bus.
//
// Each access is captured in IDLE and issued as one bus beat, or as two
// beats when a misaligned access crosses an NB-aligned word. Strobes and
// write data are steered into the lanes selected by the address offset.
// Load data is shifted back down, assembled, then sign- or zero-extended.
//
// Build option: define YARP_LSU_MISALIGN_SPLIT_EN to execute misaligned
// accesses (single shifted beat, or two beats when crossing a word).
// Without it, any misaligned access completes immediately with an error.
//
// Handshakes:
//   execute side: a request is taken on a cycle where lsu_req_i and
//   lsu_ready_o are both high; lsu_done_o pulses once per taken request
//   (never for one abandoned by reset).
//   bus side: mem_req_o and its beat fields hold steady until mem_gnt_i;
//   mem_rvalid_i then answers that beat. At most one beat is outstanding.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   lsu_req_i ..       execute-side request (addr, size, wr, data, zext)
//   lsu_ready_o        idle, able to take a request
//   lsu_done_o         one-cycle completion pulse
//   lsu_err_o          error flag, valid with lsu_done_o
//   lsu_rd_data_o      extended load data, held until the next completion
//   mem_*_o            bus beat: req, aligned addr, byte strobes, wr, data
//   mem_gnt_i          beat accepted
//   mem_rvalid_i       response for the granted beat (rd data, err)
module yarp_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lsu_req_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic [1:0]          lsu_size_i,
  input  logic                lsu_wr_i,
  input  logic [DATA_W-1:0]   lsu_wr_data_i,
  input  logic                lsu_zero_extnd_i,
  output logic                lsu_ready_o,
  output logic                lsu_done_o,
  output logic                lsu_err_o,
  output logic [DATA_W-1:0]   lsu_rd_data_o,
  output logic                mem_req_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic                mem_wr_o,
  output logic [DATA_W-1:0]   mem_wr_data_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rd_data_i,
  input  logic                mem_err_i
);

  localparam int NB       = DATA_W / 8;
  localparam int OFF_W    = $clog2(NB);
  localparam int MAX_SIZE = OFF_W;  // largest legal log2(bytes)

  typedef enum logic [2:0] {IDLE, REQ1, RSP1, REQ2, RSP2, DONE} state_t;
  state_t state, state_nxt;

  // Captured request
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              zext_q;
  logic              err_q;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] rd_q;

  // Request decode from the live inputs (used only when accepting)
  logic [OFF_W-1:0] in_off;
  logic [OFF_W-1:0] in_lowmask;
  logic             in_illegal;
  logic             in_mis;
  logic             reject;
  logic             go_second;

  assign in_off     = lsu_addr_i[OFF_W-1:0];
  assign in_lowmask = OFF_W'((5'd1 << lsu_size_i) - 5'd1);
  assign in_illegal = int'(lsu_size_i) > MAX_SIZE;
  assign in_mis     = |(in_off & in_lowmask);

`ifdef YARP_LSU_MISALIGN_SPLIT_EN
  logic in_cross;
  logic cross_q;
  assign in_cross = (5'(in_off) + (5'd1 << lsu_size_i)) > 5'(NB);
  assign reject    = in_illegal;
  assign go_second = cross_q;

  always_ff @(posedge clk) begin
    if (reset)                          cross_q <= 1'b0;
    else if (state == IDLE && lsu_req_i) cross_q <= in_cross;
  end
`else
  assign reject    = in_illegal | in_mis;
  assign go_second = 1'b0;
`endif

  // Beat geometry from the captured request. The double-width products
  // hold both beats: low half is beat 1, high half is beat 2.
  logic [OFF_W-1:0]    off_q;
  logic [3:0]          n_q;
  logic [2*NB-1:0]     be_wide;
  logic [2*DATA_W-1:0] wd_wide;
  logic [ADDR_W-1:0]   beat1_addr;

  assign off_q      = addr_q[OFF_W-1:0];
  assign n_q        = 4'd1 << size_q;
  assign be_wide    = (2*NB)'((1 << n_q) - 1) << off_q;
  assign wd_wide    = {{DATA_W{1'b0}}, wdata_q} << (8 * off_q);
  assign beat1_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Beat 1 lanes land at byte 0; beat 2 lanes continue at byte NB-off.
  logic [DATA_W-1:0] asm1, asm2;
  assign asm1 = (mem_rd_data_i & lane_mask(be_wide[NB-1:0])) >> (8 * off_q);
  assign asm2 = asm_q | ((mem_rd_data_i & lane_mask(be_wide[2*NB-1:NB]))
                         << (8 * (NB - int'(off_q))));

  // Extension of the assembled bytes
  logic              sign_bit;
  logic [7:0]        fill;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] rd_comb;

  always_comb begin
    case (size_q)
      2'd0:    sign_bit = asm_q[7];
      2'd1:    sign_bit = asm_q[15];
      default: sign_bit = asm_q[31];  // full-width doubles take no fill
    endcase
    fill     = zext_q ? 8'h00 : {8{sign_bit}};
    ext_data = '0;
    for (int i = 0; i < NB; i++)
      ext_data[8*i +: 8] = (i < int'(n_q)) ? asm_q[8*i +: 8] : fill;
    rd_comb = (wr_q || err_q) ? '0 : ext_data;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (lsu_req_i) state_nxt = reject ? DONE : REQ1;
      REQ1: if (mem_gnt_i) state_nxt = RSP1;
      RSP1: if (mem_rvalid_i)
              state_nxt = (go_second && !mem_err_i && !err_q) ? REQ2 : DONE;
      REQ2: if (mem_gnt_i) state_nxt = RSP2;
      RSP2: if (mem_rvalid_i) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    lsu_ready_o   = 1'b0;
    lsu_done_o    = 1'b0;
    lsu_err_o     = 1'b0;
    lsu_rd_data_o = rd_q;
    mem_req_o     = 1'b0;
    mem_addr_o    = '0;
    mem_be_o      = '0;
    mem_wr_o      = 1'b0;
    mem_wr_data_o = '0;
    case (state)
      IDLE: lsu_ready_o = 1'b1;
      REQ1: begin
        mem_req_o     = 1'b1;
        mem_addr_o    = beat1_addr;
        mem_be_o      = be_wide[NB-1:0];
        mem_wr_o      = wr_q;
        mem_wr_data_o = wd_wide[DATA_W-1:0];
      end
      REQ2: begin
        mem_req_o     = 1'b1;
        mem_addr_o    = beat1_addr + ADDR_W'(NB);
        mem_be_o      = be_wide[2*NB-1:NB];
        mem_wr_o      = wr_q;
        mem_wr_data_o = wd_wide[2*DATA_W-1:DATA_W];
      end
      DONE: begin
        lsu_done_o    = 1'b1;
        lsu_err_o     = err_q;
        lsu_rd_data_o = rd_comb;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      zext_q  <= 1'b0;
      err_q   <= 1'b0;
      asm_q   <= '0;
      rd_q    <= '0;
    end else begin
      case (state)
        IDLE: if (lsu_req_i) begin
          addr_q  <= lsu_addr_i;
          size_q  <= lsu_size_i;
          wr_q    <= lsu_wr_i;
          wdata_q <= lsu_wr_data_i;
          zext_q  <= lsu_zero_extnd_i;
          err_q   <= reject;
          asm_q   <= '0;
        end
        RSP1: if (mem_rvalid_i) begin
          asm_q <= asm1;
          err_q <= err_q | mem_err_i;
        end
        RSP2: if (mem_rvalid_i) begin
          asm_q <= asm2;
          err_q <= err_q | mem_err_i;
        end
        DONE: rd_q <= rd_comb;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_yarp_lsu.sv
// Bench for yarp_lsu (ADDR_W=32, DATA_W=32). Follows the build option
// YARP_LSU_MISALIGN_SPLIT_EN for the misaligned-access expectations.
module tb_yarp_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_req_i;
  logic [31:0] lsu_addr_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_wr_i;
  logic [31:0] lsu_wr_data_i;
  logic        lsu_zero_extnd_i;
  logic        lsu_ready_o, lsu_done_o, lsu_err_o;
  logic [31:0] lsu_rd_data_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic        mem_wr_o;
  logic [31:0] mem_wr_data_o;
  logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_rd_data_i;

  yarp_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_size_i(lsu_size_i),
    .lsu_wr_i(lsu_wr_i), .lsu_wr_data_i(lsu_wr_data_i),
    .lsu_zero_extnd_i(lsu_zero_extnd_i),
    .lsu_ready_o(lsu_ready_o), .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o),
    .lsu_rd_data_o(lsu_rd_data_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
    .mem_wr_o(mem_wr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rd_data_i(mem_rd_data_i), .mem_err_i(mem_err_i)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard: expected lsu_rd_data_o per access, in issue order
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  // observations of the last access
  logic [31:0] ob_addr[2];
  logic [3:0]  ob_be[2];
  logic        ob_wr[2];
  logic [31:0] ob_wd[2];
  int          n_beats, done_cyc, first_req_cyc;
  logic        ob_done, ob_err, ob_stable;
  logic [31:0] ob_rd;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_load(input logic [63:0] pair, input int off,
                                             input int n, input logic zext);
    logic [31:0] r;
    logic s;
    s = pair[8*(off+n)-1];
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = (i < n) ? pair[8*(off+i) +: 8] : (zext ? 8'h00 : {8{s}});
    return r;
  endfunction

  function automatic logic [3:0] model_be(input int off, input int n);
    logic [3:0] b;
    for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + n);
    return b;
  endfunction

  // ---------------- driver ----------------
  // Issues one request and plays the memory side. Cycle numbers count
  // negedges after the accepting edge (cycle 1 = T+1).
  task automatic run_access(input logic [31:0] addr, input logic [1:0] size,
                            input logic wr, input logic [31:0] wd, input logic zext,
                            input int gnt_wait, input int rv_wait,
                            input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic err1);
    int gw, rw, phase;
    logic [31:0] hold_addr;
    logic [3:0]  hold_be;
    n_beats = 0; ob_done = 0; ob_err = 0; ob_rd = '0; done_cyc = -1;
    first_req_cyc = -1; ob_stable = 1; gw = 0; rw = 0; phase = 0;
    hold_addr = '0; hold_be = '0;
    @(negedge clk);
    lsu_req_i = 1; lsu_addr_i = addr; lsu_size_i = size; lsu_wr_i = wr;
    lsu_wr_data_i = wd; lsu_zero_extnd_i = zext;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rd_data_i = '0;
      if (lsu_done_o) begin
        ob_done = 1; ob_rd = lsu_rd_data_o; ob_err = lsu_err_o; done_cyc = cyc;
        break;
      end
      if (mem_req_o) begin
        if (first_req_cyc < 0) first_req_cyc = cyc;
        if (gw == 0) begin hold_addr = mem_addr_o; hold_be = mem_be_o; end
        else if (mem_addr_o !== hold_addr || mem_be_o !== hold_be) ob_stable = 0;
        if (gw >= gnt_wait) begin
          mem_gnt_i = 1;
          if (n_beats < 2) begin
            ob_addr[n_beats] = mem_addr_o; ob_be[n_beats] = mem_be_o;
            ob_wr[n_beats] = mem_wr_o; ob_wd[n_beats] = mem_wr_data_o;
          end
          n_beats++; gw = 0; rw = 0; phase = 1;
        end else gw++;
      end else if (phase == 1) begin
        if (rw >= rv_wait) begin
          mem_rvalid_i = 1;
          mem_rd_data_i = (n_beats == 1) ? rd1 : rd2;
          mem_err_i = (n_beats == 1) ? err1 : 1'b0;
          phase = 0;
        end else rw++;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1; lsu_req_i = 0; lsu_addr_i = '0; lsu_size_i = '0; lsu_wr_i = 0;
    lsu_wr_data_i = '0; lsu_zero_extnd_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rd_data_i = '0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    n_cmp++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", lsu_ready_o); end
    n_cmp++; if (lsu_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", lsu_done_o); end
    n_cmp++; if (lsu_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", lsu_err_o); end
    n_cmp++; if (lsu_rd_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_rd: got %h want 0", lsu_rd_data_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", mem_req_o); end
    n_cmp++; if ({mem_addr_o, mem_be_o, mem_wr_o, mem_wr_data_o} !== 69'h0) begin
      n_fail++; $display("FAIL rst_bus: got %h/%h/%b/%h want 0", mem_addr_o, mem_be_o, mem_wr_o, mem_wr_data_o); end
  endtask

  task automatic test_word_load();
    exp_q.push_back(32'h8BADF00D);
    run_access(32'h100, 2'd2, 0, '0, 0, 0, 0, 32'h8BADF00D, '0, 0);
    n_cmp++; if (ob_addr[0] !== 32'h100) begin n_fail++; $display("FAIL wl_addr: got %h want 100", ob_addr[0]); end
    n_cmp++; if (ob_be[0] !== 4'hF) begin n_fail++; $display("FAIL wl_be: got %h want f", ob_be[0]); end
    n_cmp++; if (first_req_cyc !== 1) begin n_fail++; $display("FAIL wl_req_lat: got %0d want 1", first_req_cyc); end
    n_cmp++; if (done_cyc !== 3) begin n_fail++; $display("FAIL wl_done_lat: got %0d want 3", done_cyc); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (ob_rd !== exp_v) begin n_fail++; $display("FAIL wl_rd: got %h want %h", ob_rd, exp_v); end
    n_cmp++; if (ob_err !== 1'b0) begin n_fail++; $display("FAIL wl_err: got %b want 0", ob_err); end
  endtask

  task automatic test_byte_load();
    for (int z = 0; z < 2; z++) begin
      exp_q.push_back(z == 1 ? 32'h00000080 : 32'hFFFFFF80);
      run_access(32'h103, 2'd0, 0, '0, z[0], 0, 0, 32'h80123456, '0, 0);
      n_cmp++; if (ob_be[0] !== 4'h8) begin n_fail++; $display("FAIL bl_be z=%0d: got %h want 8", z, ob_be[0]); end
      exp_v = exp_q.pop_front();
      n_cmp++; if (ob_rd !== exp_v || !ob_done) begin n_fail++; $display("FAIL bl_rd z=%0d: got %h want %h", z, ob_rd, exp_v); end
    end
  endtask

  task automatic test_half_store();
    exp_q.push_back(32'h0);
    run_access(32'h102, 2'd1, 1, 32'h0000BEEF, 0, 1, 1, 32'hFFFFFFFF, '0, 0);
    n_cmp++; if (ob_be[0] !== 4'hC) begin n_fail++; $display("FAIL hs_be: got %h want c", ob_be[0]); end
    n_cmp++; if (ob_wd[0] !== 32'hBEEF0000) begin n_fail++; $display("FAIL hs_wd: got %h want beef0000", ob_wd[0]); end
    n_cmp++; if (ob_wr[0] !== 1'b1) begin n_fail++; $display("FAIL hs_wr: got %b want 1", ob_wr[0]); end
    n_cmp++; if (done_cyc !== 5) begin n_fail++; $display("FAIL hs_done_lat: got %0d want 5", done_cyc); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (ob_rd !== exp_v || ob_err !== 1'b0) begin n_fail++; $display("FAIL hs_rd: got %h/%b want %h/0", ob_rd, ob_err, exp_v); end
  endtask

  task automatic test_misaligned();
    // illegal size on a 32-bit bus: immediate error, no bus beat
    run_access(32'h100, 2'd3, 0, '0, 0, 0, 0, '0, '0, 0);
    n_cmp++; if (!(done_cyc == 1 && ob_err === 1'b1 && n_beats == 0 && ob_rd === 32'h0)) begin
      n_fail++; $display("FAIL ill_size: got cyc=%0d err=%b beats=%0d rd=%h want 1/1/0/0", done_cyc, ob_err, n_beats, ob_rd); end
`ifdef YARP_LSU_MISALIGN_SPLIT_EN
    exp_q.push_back(32'h77881122);
    run_access(32'h102, 2'd2, 0, '0, 0, 0, 0, 32'h11223344, 32'h55667788, 0);
    n_cmp++; if (n_beats !== 2) begin n_fail++; $display("FAIL sp_beats: got %0d want 2", n_beats); end
    n_cmp++; if (ob_addr[0] !== 32'h100 || ob_be[0] !== 4'hC) begin n_fail++; $display("FAIL sp_beat1: got %h/%h want 100/c", ob_addr[0], ob_be[0]); end
    n_cmp++; if (ob_addr[1] !== 32'h104 || ob_be[1] !== 4'h3) begin n_fail++; $display("FAIL sp_beat2: got %h/%h want 104/3", ob_addr[1], ob_be[1]); end
    n_cmp++; if (done_cyc !== 5) begin n_fail++; $display("FAIL sp_done_lat: got %0d want 5", done_cyc); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (ob_rd !== exp_v || ob_err !== 1'b0) begin n_fail++; $display("FAIL sp_rd: got %h/%b want %h/0", ob_rd, ob_err, exp_v); end
    // misaligned half inside one word: single shifted beat
    exp_q.push_back(model_load({32'h0, 32'hAABBCCDD}, 1, 2, 0));
    run_access(32'h101, 2'd1, 0, '0, 0, 0, 0, 32'hAABBCCDD, '0, 0);
    n_cmp++; if (n_beats !== 1 || ob_be[0] !== 4'h6) begin n_fail++; $display("FAIL mh_be: got %0d/%h want 1/6", n_beats, ob_be[0]); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (ob_rd !== exp_v || ob_err !== 1'b0) begin n_fail++; $display("FAIL mh_rd: got %h/%b want %h/0", ob_rd, ob_err, exp_v); end
`else
    run_access(32'h102, 2'd2, 0, '0, 0, 0, 0, 32'h11223344, 32'h55667788, 0);
    n_cmp++; if (!(done_cyc == 1 && ob_err === 1'b1 && n_beats == 0 && first_req_cyc == -1)) begin
      n_fail++; $display("FAIL mis_word: got cyc=%0d err=%b beats=%0d want 1/1/0", done_cyc, ob_err, n_beats); end
    run_access(32'h101, 2'd1, 1, 32'h1234, 0, 0, 0, '0, '0, 0);
    n_cmp++; if (!(done_cyc == 1 && ob_err === 1'b1 && n_beats == 0 && ob_rd === 32'h0)) begin
      n_fail++; $display("FAIL mis_half: got cyc=%0d err=%b beats=%0d rd=%h want 1/1/0/0", done_cyc, ob_err, n_beats, ob_rd); end
`endif
  endtask

  task automatic test_stall_reset();
    int dones;
    run_access(32'h240, 2'd2, 0, '0, 0, 4, 0, 32'hCAFE0001, '0, 0);
    n_cmp++; if (ob_stable !== 1'b1) begin n_fail++; $display("FAIL st_stable: got %b want 1", ob_stable); end
    n_cmp++; if (done_cyc !== 7 || ob_rd !== 32'hCAFE0001) begin n_fail++; $display("FAIL st_done: got %0d/%h want 7/cafe0001", done_cyc, ob_rd); end
    // abandon a load in RSP1
    @(negedge clk);
    lsu_req_i = 1; lsu_addr_i = 32'h200; lsu_size_i = 2'd2; lsu_wr_i = 0;
    @(negedge clk);
    lsu_req_i = 0;
    n_cmp++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rs_req: got %b want 1", mem_req_o); end
    mem_gnt_i = 1;
    @(negedge clk);
    mem_gnt_i = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    n_cmp++; if (lsu_ready_o !== 1'b1 || mem_req_o !== 1'b0 || lsu_done_o !== 1'b0) begin
      n_fail++; $display("FAIL rs_idle: got ready=%b req=%b done=%b want 1/0/0", lsu_ready_o, mem_req_o, lsu_done_o); end
    mem_rvalid_i = 1; mem_rd_data_i = 32'hDEAD0000;
    @(negedge clk);
    mem_rvalid_i = 0; mem_rd_data_i = '0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      if (lsu_done_o) dones++;
      @(negedge clk);
    end
    n_cmp++; if (dones != 0 || lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL rs_stray: got dones=%0d ready=%b want 0/1", dones, lsu_ready_o); end
  endtask

  task automatic test_wrap_err();
`ifdef YARP_LSU_MISALIGN_SPLIT_EN
    run_access(32'hFFFFFFFE, 2'd2, 0, '0, 0, 0, 0, 32'h11223344, 32'h55667788, 1);
    n_cmp++; if (n_beats !== 1 || ob_addr[0] !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL we_beats: got %0d/%h want 1/fffffffc", n_beats, ob_addr[0]); end
    n_cmp++; if (ob_err !== 1'b1 || ob_rd !== 32'h0 || !ob_done) begin n_fail++; $display("FAIL we_err: got %b/%h want 1/0", ob_err, ob_rd); end
    exp_q.push_back(model_load({32'hA1B2C3D4, 32'h99887766}, 2, 4, 0));
    run_access(32'hFFFFFFFE, 2'd2, 0, '0, 0, 0, 0, 32'h99887766, 32'hA1B2C3D4, 0);
    n_cmp++; if (n_beats !== 2 || ob_addr[1] !== 32'h0) begin n_fail++; $display("FAIL wr_addr2: got %0d/%h want 2/0", n_beats, ob_addr[1]); end
    exp_v = exp_q.pop_front();
    n_cmp++; if (ob_rd !== exp_v || ob_err !== 1'b0) begin n_fail++; $display("FAIL wr_rd: got %h/%b want %h/0", ob_rd, ob_err, exp_v); end
`else
    run_access(32'hFFFFFFFE, 2'd2, 0, '0, 0, 0, 0, 32'h11223344, 32'h55667788, 1);
    n_cmp++; if (!(done_cyc == 1 && ob_err === 1'b1 && n_beats == 0)) begin
      n_fail++; $display("FAIL wrap_mis: got cyc=%0d err=%b beats=%0d want 1/1/0", done_cyc, ob_err, n_beats); end
`endif
    // a following good access clears the error
    exp_q.push_back(32'h0000A5A5);
    run_access(32'hFFFFFFFC, 2'd1, 0, '0, 1, 0, 0, 32'h1234A5A5, '0, 0);
    exp_v = exp_q.pop_front();
    n_cmp++; if (ob_rd !== exp_v || ob_err !== 1'b0) begin n_fail++; $display("FAIL wrap_next: got %h/%b want %h/0", ob_rd, ob_err, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d, r;
    int sz, n, off, gw, rw;
    logic wr, z;
    for (int k = 0; k < 24; k++) begin
      sz = $urandom_range(2, 0); n = 1 << sz;
      off = $urandom_range(3, 0) & ~(n - 1);
      a = ($urandom() & 32'hFFFFFFFC) | off;
      wr = $urandom_range(1, 0); z = $urandom_range(1, 0);
      d = $urandom() >> (32 - 8 * n); r = $urandom();
      gw = $urandom_range(2, 0); rw = $urandom_range(2, 0);
      exp_q.push_back(wr ? 32'h0 : model_load({32'h0, r}, off, n, z));
      run_access(a, sz[1:0], wr, d, z, gw, rw, r, '0, 0);
      n_cmp++; if (ob_be[0] !== model_be(off, n) || ob_addr[0] !== (a & 32'hFFFFFFFC)) begin
        n_fail++; $display("FAIL bb_beat k=%0d: got %h/%h want %h/%h", k, ob_addr[0], ob_be[0], a & 32'hFFFFFFFC, model_be(off, n)); end
      if (wr) begin
        n_cmp++; if (ob_wd[0] !== (d << (8 * off)) || ob_wr[0] !== 1'b1) begin
          n_fail++; $display("FAIL bb_wd k=%0d: got %h/%b want %h/1", k, ob_wd[0], ob_wr[0], d << (8 * off)); end
      end
      exp_v = exp_q.pop_front();
      n_cmp++; if (!ob_done || ob_rd !== exp_v || ob_err !== 1'b0 || done_cyc !== 3 + gw + rw) begin
        n_fail++; $display("FAIL bb_rd k=%0d: got %h/%b cyc=%0d want %h/0 cyc=%0d", k, ob_rd, ob_err, done_cyc, exp_v, 3 + gw + rw); end
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_misaligned();
    test_stall_reset();
    test_wrap_err();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
